// File: rtl/idex_stage_if.sv
// ID/EX stage bundle: decoded ID fields in, registered EX-side copies plus stall and bubble count out.
// The master modport is the ID/control side that drives the stage; slave is the stage itself.
interface idex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              i_enable;
  logic              i_flush;
  logic [DATA_W-1:0] i_ID_pc4;
  logic [DATA_W-1:0] i_ID_rs_data;
  logic [DATA_W-1:0] i_ID_rt_data;
  logic [DATA_W-1:0] i_ID_imm;
  logic [4:0]        i_ID_rs;
  logic [4:0]        i_ID_rt;
  logic [4:0]        i_ID_rd;
  logic [4:0]        i_ID_shamt;
  logic [7:0]        i_ID_ctrl;

  logic              o_stall;
  logic [DATA_W-1:0] o_IDEX_pc4;
  logic [DATA_W-1:0] o_IDEX_rs_data;
  logic [DATA_W-1:0] o_IDEX_rt_data;
  logic [DATA_W-1:0] o_IDEX_imm;
  logic [4:0]        o_IDEX_rs;
  logic [4:0]        o_IDEX_rt;
  logic [4:0]        o_IDEX_rd;
  logic [4:0]        o_IDEX_shamt;
  logic [7:0]        o_IDEX_ctrl;
  logic              o_IDEX_valid;
  logic [CNT_W-1:0]  o_bubble_count;

  modport master (
    output i_enable, i_flush, i_ID_pc4, i_ID_rs_data, i_ID_rt_data, i_ID_imm,
           i_ID_rs, i_ID_rt, i_ID_rd, i_ID_shamt, i_ID_ctrl,
    input  o_stall, o_IDEX_pc4, o_IDEX_rs_data, o_IDEX_rt_data, o_IDEX_imm,
           o_IDEX_rs, o_IDEX_rt, o_IDEX_rd, o_IDEX_shamt, o_IDEX_ctrl,
           o_IDEX_valid, o_bubble_count
  );

  modport slave (
    input  i_enable, i_flush, i_ID_pc4, i_ID_rs_data, i_ID_rt_data, i_ID_imm,
           i_ID_rs, i_ID_rt, i_ID_rd, i_ID_shamt, i_ID_ctrl,
    output o_stall, o_IDEX_pc4, o_IDEX_rs_data, o_IDEX_rt_data, o_IDEX_imm,
           o_IDEX_rs, o_IDEX_rt, o_IDEX_rd, o_IDEX_shamt, o_IDEX_ctrl,
           o_IDEX_valid, o_bubble_count
  );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use detection: one-cycle latency, ID held via o_stall for one
// cycle on a hazard against the load in EX; flush or hazard loads a counted (saturating) bubble.
module idex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  idex_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [7:0]        ctrl;
    logic              valid;
  } idex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int MEMREAD_BIT = 6;

  idex_t            stage_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic             load_use;

  // Bubbles carry rt=0 and valid=0, so a bubble in EX can never re-trigger the detector.
  always_comb begin
    load_use = 1'b0;
    if (stage_q.ctrl[MEMREAD_BIT] && stage_q.valid && (stage_q.rt != 5'd0) &&
        ((stage_q.rt == bus.i_ID_rs) || (stage_q.rt == bus.i_ID_rt)))
      load_use = 1'b1;
  end

  // A concurrent flush discards the waiting instruction anyway, so let the PC advance.
  assign bus.o_stall = load_use && !bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else if (bus.i_enable) begin
      if (bus.i_flush || load_use) begin
        stage_q <= '0;
        if (bubble_cnt_q != CNT_MAX)
          bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end else begin
        stage_q <= '{pc4:     bus.i_ID_pc4,
                     rs_data: bus.i_ID_rs_data,
                     rt_data: bus.i_ID_rt_data,
                     imm:     bus.i_ID_imm,
                     rs:      bus.i_ID_rs,
                     rt:      bus.i_ID_rt,
                     rd:      bus.i_ID_rd,
                     shamt:   bus.i_ID_shamt,
                     ctrl:    bus.i_ID_ctrl,
                     valid:   1'b1};
      end
    end
  end

  assign bus.o_IDEX_pc4     = stage_q.pc4;
  assign bus.o_IDEX_rs_data = stage_q.rs_data;
  assign bus.o_IDEX_rt_data = stage_q.rt_data;
  assign bus.o_IDEX_imm     = stage_q.imm;
  assign bus.o_IDEX_rs      = stage_q.rs;
  assign bus.o_IDEX_rt      = stage_q.rt;
  assign bus.o_IDEX_rd      = stage_q.rd;
  assign bus.o_IDEX_shamt   = stage_q.shamt;
  assign bus.o_IDEX_ctrl    = stage_q.ctrl;
  assign bus.o_IDEX_valid   = stage_q.valid;
  assign bus.o_bubble_count = bubble_cnt_q;

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register with an integrated load-use hazard detector for the 5-stage MIPS core.
- Captures decoded operands, register addresses and control bits from ID. Presents them to EX, including the Rs/Rt/MemRead fields consumed by the forwarding unit.
- Detects load-use hazards against the instruction currently in EX. Requests a PC/IF-ID hold and inserts a bubble.
- Honours branch flush and the debug-unit step enable, and counts inserted bubbles for debug readout.

Parameters:
DATA_W, 32, width of PC, operand and immediate fields
CNT_W, 16, width of saturating bubble counter

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  debug step enable; 0 freezes all state
i_flush  in  1  kill instruction entering EX (taken branch/jump)
i_ID_pc4  in  DATA_W  PC+4 of ID instruction
i_ID_rs_data  in  DATA_W  register file read port A
i_ID_rt_data  in  DATA_W  register file read port B
i_ID_imm  in  DATA_W  extended immediate
i_ID_rs  in  5  Rs field
i_ID_rt  in  5  Rt field
i_ID_rd  in  5  Rd field
i_ID_shamt  in  5  shift amount
i_ID_ctrl  in  8  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[1:0]}
o_stall  out  1  hold PC and IF/ID this cycle
o_IDEX_pc4, o_IDEX_rs_data, o_IDEX_rt_data, o_IDEX_imm  out  DATA_W each  registered copies
o_IDEX_rs, o_IDEX_rt, o_IDEX_rd, o_IDEX_shamt  out  5 each  registered copies
o_IDEX_ctrl  out  8  registered control
o_IDEX_valid  out  1  1 = real instruction, 0 = bubble
o_bubble_count  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (i_reset=1 at an edge) has priority over all other inputs, i_enable included.
  - Every registered output is cleared to 0, including o_IDEX_valid and o_bubble_count.
  - o_stall evaluates from the cleared state, so it is 0.
- Hazard detection is combinational from registered state and ID inputs.
  - load_use = o_IDEX_ctrl.MemRead && o_IDEX_valid && o_IDEX_rt != 0 && (o_IDEX_rt == i_ID_rs || o_IDEX_rt == i_ID_rt).
  - o_stall = load_use && !i_flush. It does not depend on i_enable.
- Register update at a rising edge, in priority order:
  1. i_reset: clear all state.
  2. !i_enable: hold every register, counter included.
  3. i_flush: load a bubble; counter +1.
  4. load_use: load a bubble; counter +1.
  5. Otherwise: load all ID fields; o_IDEX_valid = 1.
- Bubble definition:
  - ctrl = 0, rs = rt = rd = shamt = 0.
  - All data fields = 0, valid = 0.
  - The forwarding unit therefore sees RegWrite=0 downstream, and the detector cannot re-trigger on a bubble.
- Latency: one cycle from ID inputs to o_IDEX_*.
- A load-use stall lasts exactly one cycle. The next cycle EX holds a bubble (MemRead=0), so load_use deasserts and the held ID instruction loads.
- Flush and load_use in the same cycle: one bubble, counted once; o_stall = 0, so the PC advances to the branch target.
- Counter saturates at 2^CNT_W-1 and never wraps.
- Reset mid-stall: the next cycle has o_stall = 0 and an empty stage.
- Register 0 as load destination never stalls.

Test Plan:
- Reset: drive random inputs, i_reset=1 for 2 cycles -> all o_IDEX_* = 0, o_IDEX_valid=0, o_stall=0, o_bubble_count=0.
- Pass-through: load ID rs=3, rt=4, rd=5, ctrl=8'h80, imm=32'h0000_0010 -> next cycle o_IDEX_* match exactly, valid=1, o_stall=0.
- Load-use on Rs:
  - EX holds lw with rt=8 (MemRead=1); ID holds add rs=8.
  - Expected: o_stall=1 for exactly one cycle, then a bubble (ctrl=0, valid=0, count=1), then add loads with valid=1.
  - Repeat with rt=0 -> no stall.
- Flush+hazard collision: same hazard with i_flush=1 -> o_stall=0, one bubble, count increments by exactly 1.
- Enable freeze: i_enable=0 for 3 cycles while ID inputs change -> outputs and count unchanged; resume with i_enable=1 -> next ID instruction loads.
- Saturation (CNT_W=4): force 20 consecutive flushes -> o_bubble_count stops at 15.
